// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_lvl family.
//   cnt_width  : width needed to hold an occupancy of 0..depth
//   ptr_width  : width needed to index 0..depth-1
//   next_ptr   : wrap increment for arbitrary (non power-of-two) depths
//   fifo_err_t : sticky error flags, also intended for future status registers
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Explicit compare against depth-1 so any depth wraps correctly.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_lvl_ptr.sv
// Wrap counter used as a FIFO read or write index.
//   i_clk : clock, rising edge
//   i_clr : synchronous clear to 0 (reset or flush), has priority over i_en
//   i_en  : advance by one, wrapping Depth-1 -> 0
//   o_ptr : current index, always within 0..Depth-1
module fifo_lvl_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned  Depth = 8,
    localparam int unsigned PtrW  = ptr_width(Depth)
) (
    input  logic            i_clk,
    input  logic            i_clr,
    input  logic            i_en,
    output logic [PtrW-1:0] o_ptr
);

    logic [PtrW-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= PtrW'(next_ptr(32'(r_ptr), Depth));
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_lvl.sv
// Single-clock show-ahead FIFO with arbitrary depth, occupancy count,
// programmable almost-full/almost-empty levels, flush and sticky errors.
//   i_clk, i_rst           : clock and synchronous active-high reset
//   i_flush                : empty the FIFO (memory untouched)
//   i_clr_err              : clear sticky overflow/underflow
//   i_push, i_wdata        : write request and data
//   i_pop, o_rdata         : read request; o_rdata is the current head
//   o_full, o_empty        : count == Depth / count == 0
//   i_af_thresh, i_ae_thresh, o_almost_full, o_almost_empty : level flags
//   o_count                : occupancy 0..Depth
//   o_overflow, o_underflow: sticky error flags
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int unsigned  Width = 8,
    parameter int unsigned  Depth = 8,
    localparam int unsigned CntW  = cnt_width(Depth)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_clr_err,
    input  logic             i_push,
    input  logic [Width-1:0] i_wdata,
    input  logic             i_pop,
    output logic [Width-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    input  logic [CntW-1:0]  i_af_thresh,
    input  logic [CntW-1:0]  i_ae_thresh,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [CntW-1:0]  o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int unsigned PtrW = ptr_width(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [CntW-1:0]  r_count;
    fifo_err_t        r_err;
    fifo_err_t        w_err_new;
    logic [PtrW-1:0]  w_wptr;
    logic [PtrW-1:0]  w_rptr;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_ptr_clr;

    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);

    // Flush discards same-cycle traffic, so it gates the accepted strobes.
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_ptr_clr = i_rst | i_flush;

    fifo_lvl_ptr #(
        .Depth (Depth)
    ) u_wptr (
        .i_clk (i_clk),
        .i_clr (w_ptr_clr),
        .i_en  (w_do_push),
        .o_ptr (w_wptr)
    );

    fifo_lvl_ptr #(
        .Depth (Depth)
    ) u_rptr (
        .i_clk (i_clk),
        .i_clr (w_ptr_clr),
        .i_en  (w_do_pop),
        .o_ptr (w_rptr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[w_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_count <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CntW'(1);
        end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - CntW'(1);
        end
    end

    // Errors are not raised for traffic discarded by a flush.
    assign w_err_new.overflow  = i_push & o_full & ~i_flush;
    assign w_err_new.underflow = i_pop & o_empty & ~i_flush;

    // A new error in the same cycle as i_clr_err keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= '0;
        end else if (i_clr_err) begin
            r_err <= w_err_new;
        end else begin
            r_err.overflow  <= r_err.overflow | w_err_new.overflow;
            r_err.underflow <= r_err.underflow | w_err_new.underflow;
        end
    end

    // Pointer is always within 0..Depth-1 by construction of next_ptr.
    assign o_rdata        = r_mem[w_rptr];
    assign o_count        = r_count;
    assign o_almost_full  = (r_count >= i_af_thresh);
    assign o_almost_empty = (r_count <= i_ae_thresh);
    assign o_overflow     = r_err.overflow;
    assign o_underflow    = r_err.underflow;

endmodule

// File: tb/tb_fifo_lvl.sv
module tb_fifo_lvl;

    localparam int Width = 8;
    localparam int Depth = 5;
    localparam int CntW  = $clog2(Depth + 1);

    logic             clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_flush = 1'b0;
    logic             i_clr_err = 1'b0;
    logic             i_push = 1'b0;
    logic [Width-1:0] i_wdata = '0;
    logic             i_pop = 1'b0;
    logic [Width-1:0] o_rdata;
    logic             o_full;
    logic             o_empty;
    logic [CntW-1:0]  af = '0;
    logic [CntW-1:0]  ae = '0;
    logic             o_almost_full;
    logic             o_almost_empty;
    logic [CntW-1:0]  o_count;
    logic             o_overflow;
    logic             o_underflow;

    always #5 clk = ~clk;

    fifo_lvl #(
        .Width (Width),
        .Depth (Depth)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_flush        (i_flush),
        .i_clr_err      (i_clr_err),
        .i_push         (i_push),
        .i_wdata        (i_wdata),
        .i_pop          (i_pop),
        .o_rdata        (o_rdata),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .i_af_thresh    (af),
        .i_ae_thresh    (ae),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents as a plain queue plus two sticky bits.
    logic [Width-1:0] mq[$];
    bit               m_ovf = 0;
    bit               m_unf = 0;
    // Scoreboard of data expected on each accepted pop.
    logic [Width-1:0] exp_q[$];
    logic [Width-1:0] exp_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = mq.size();
        check("count", 32'(o_count), n);
        check("empty", 32'(o_empty), 32'(n == 0));
        check("full", 32'(o_full), 32'(n == Depth));
        check("almost_full", 32'(o_almost_full), 32'(n >= int'(af)));
        check("almost_empty", 32'(o_almost_empty), 32'(n <= int'(ae)));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
        check("underflow", 32'(o_underflow), 32'(m_unf));
        if (n > 0) check("head", 32'(o_rdata), 32'(mq[0]));
    endtask

    // Apply one cycle of stimulus, advance the model past the edge, check state.
    task automatic step(input bit push, input logic [Width-1:0] wd, input bit pop,
                        input bit flush = 0, input bit clr = 0, input bit rst = 0);
        int  pre;
        bit  acc_push;
        bit  acc_pop;
        i_push    = push;
        i_wdata   = wd;
        i_pop     = pop;
        i_flush   = flush;
        i_clr_err = clr;
        i_rst     = rst;
        pre       = mq.size();
        acc_pop   = !rst && !flush && pop && pre > 0;
        acc_push  = !rst && !flush && push && pre < Depth;
        if (acc_pop) exp_q.push_back(mq[0]);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (flush) begin
            mq.delete();
            if (clr) begin
                m_ovf = 0;
                m_unf = 0;
            end
        end else begin
            bit novf;
            bit nunf;
            novf = push && pre == Depth;
            nunf = pop && pre == 0;
            if (clr) begin
                m_ovf = novf;
                m_unf = nunf;
            end else begin
                m_ovf = m_ovf | novf;
                m_unf = m_unf | nunf;
            end
            if (acc_pop) void'(mq.pop_front());
            if (acc_push) mq.push_back(wd);
        end
        check_state();
    endtask

    // Monitor: whenever the DUT accepts a pop, the head must match the scoreboard.
    always @(negedge clk) begin
        if (i_pop && !o_empty && !i_flush && !i_rst) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_data: got unexpected pop rdata=0x%0h required none", o_rdata);
            end else begin
                exp_d = exp_q.pop_front();
                check("pop_data", 32'(o_rdata), 32'(exp_d));
            end
        end
    end

    initial begin
        af = CntW'(4);
        ae = CntW'(1);
        step(0, 0, 0, 0, 0, 1);
        check("reset_rdata", 32'(o_rdata), 0);

        // Fill with 0x11..0x55, then drain in order.
        for (int i = 1; i <= Depth; i++) step(1, 8'(i * 17), 0);
        step(1, 8'h77, 0, 0, 1);  // push on full together with clr: set wins
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < Depth; i++) step(0, 0, 1);

        // Repeated fills/drains with offset start to cross the 4->0 wrap.
        step(1, 8'hE1, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < Depth - 1; i++) step(1, 8'($urandom), 0);
            for (int i = 0; i < Depth - 1; i++) step(0, 0, 1);
        end
        step(0, 0, 1);

        // Full: push with pop -> pop taken, push dropped, overflow set.
        for (int i = 0; i < Depth; i++) step(1, 8'($urandom), 0);
        step(1, 8'h66, 1);
        step(0, 0, 0, 0, 1);
        while (mq.size() > 0) step(0, 0, 1);
        step(0, 0, 1);            // underflow
        step(1, 8'h5A, 1);        // pop while empty ignored even with push
        step(0, 0, 0, 0, 1);

        // Count 2: simultaneous push/pop keeps count.
        step(1, 8'h01, 0);
        step(1, 8'hA0, 1);
        step(1, 8'hA1, 1);
        while (mq.size() > 0) step(0, 0, 1);

        // af=0 forces almost_full at count 0.
        af = CntW'(0);
        step(0, 0, 0);
        af = CntW'(4);

        // Flush with push at count 3.
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0);
        step(1, 8'hBB, 0, 1);
        // Reset with push at count 3.
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0);
        step(1, 8'hCC, 0, 0, 0, 1);
        check("reset_rdata2", 32'(o_rdata), 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                af = CntW'($urandom_range(0, 7));
                ae = CntW'($urandom_range(0, 7));
            end
            step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) == 0);
        end

        step(0, 0, 0);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_lvl.md
Name: fifo_lvl

Overview:
- Parametrised successor of the team's single-clock synchronous FIFO.
- Adds the following over the existing FIFO:
  - arbitrary (non-power-of-two) depth
  - an occupancy count
  - runtime-programmable almost-full/almost-empty thresholds
  - a synchronous flush
  - sticky overflow/underflow error flags
- Sits between producer/consumer blocks in the same clock domain, e.g. link-layer buffering ahead of the serialiser, where flow control needs early warning rather than a bare full flag.

Parameters:
- Width, 8: data word width in bits (>=1).
- Depth, 8: number of entries (>=2, any integer, not restricted to powers of two).
- CntW, $clog2(Depth+1): derived localparam, width of count and threshold ports; not overridable.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_flush  in  1  synchronous flush: empties FIFO, memory contents untouched.
- i_clr_err  in  1  clears sticky error flags.
- i_push  in  1  write request.
- i_wdata  in  Width  write data.
- i_pop  in  1  read request; o_rdata is valid in the same cycle (show-ahead).
- o_rdata  out  Width  head-of-queue data.
- o_full  out  1  count == Depth.
- o_empty  out  1  count == 0.
- i_af_thresh  in  CntW  almost-full threshold.
- i_ae_thresh  in  CntW  almost-empty threshold.
- o_almost_full  out  1  count >= i_af_thresh.
- o_almost_empty  out  1  count <= i_ae_thresh.
- o_count  out  CntW  current occupancy, 0..Depth.
- o_overflow  out  1  sticky: push attempted while full.
- o_underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset:
  - i_rst sampled high at an edge clears wptr, rptr, count, error flags and all memory entries to 0.
  - Outputs after reset: o_empty=1, o_full=0, o_count=0, o_rdata=0, o_overflow=0, o_underflow=0.
  - o_almost_* follow their combinational definitions (o_almost_empty=1 for any threshold).
  - Reset mid-operation discards all contents; it overrides flush, push, pop and clr_err.
- Storage: Depth x Width register array; write index wptr and read index rptr each range 0..Depth-1.
- Pointer wrap: increment is "ptr == Depth-1 ? 0 : ptr+1". No power-of-two masking.
- Full/empty: derived from a registered count (0..Depth), not from pointer MSB comparison.
- Accept rules:
  - do_push = i_push & !o_full.
  - do_pop = i_pop & !o_empty.
  - Both are evaluated on current-cycle state.
  - Push while full is dropped, even with a simultaneous pop; there is no pass-through.
  - Pop while empty is ignored, even with a simultaneous push.
- Latency:
  - Written data is visible on o_rdata the cycle after the push edge, when the FIFO was empty.
  - o_rdata = mem[rptr] combinationally; it advances the cycle after an accepted pop.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Both accepted: unchanged, while both pointers advance.
  - Neither: unchanged.
- Flush:
  - i_flush high (without reset) sets wptr=rptr=0 and count=0 at the edge.
  - Push/pop in the same cycle are discarded and do not set error flags.
  - Memory is not cleared.
- Errors:
  - o_overflow is set on the edge after i_push & o_full.
  - o_underflow is set on the edge after i_pop & o_empty.
  - Both flags hold until i_rst or i_clr_err.
  - If i_clr_err and a new error occur in the same cycle, set wins (the flag stays 1).
- Thresholds:
  - Compared unsigned against the registered count; purely combinational from count.
  - i_af_thresh=0 forces o_almost_full=1.
  - i_ae_thresh>=Depth forces o_almost_empty=1.
  - Thresholds may change at any time; no internal latching.
- X-safety: o_rdata never reads an index outside 0..Depth-1.

Decomposition:
- Package fifo_pkg:
  - function next_ptr(ptr, depth) for the wrap increment;
  - localparam helper for CntW;
  - typedef struct fifo_err_t {overflow, underflow}, used internally and by future status registers.
- One sub-module, fifo_lvl_ptr:
  - holds a wrap counter with synchronous clear (reset/flush) and enable;
  - instantiated twice, once for wptr and once for rptr.
- Count, flags and memory stay in fifo_lvl.

Test Plan:
- Depth=5, Width=8, reset, push 0x11..0x55 on 5 consecutive cycles -> o_count 1..5, o_full=1 after 5th edge; o_rdata=0x11 from cycle after first push.
- Continue from full: pop 5 times -> o_rdata sequence 0x11,0x22,0x33,0x44,0x55, then o_empty=1, o_count=0. Repeat 3 fills and drains to exercise non-power-of-two wrap at index 4->0, with data intact.
- At count=5, push 0x66 with simultaneous pop -> pop accepted, push dropped, o_count=4, o_overflow=1. Assert i_clr_err -> o_overflow=0 next cycle. Pop while empty -> o_underflow=1.
- At count=2, simultaneous push 0xA0 and pop -> o_count stays 2, o_rdata advances by one entry, no error flags set.
- i_af_thresh=4, i_ae_thresh=1 -> at count 0,1: o_almost_empty=1. At count 2,3: both flags 0. At count 4,5: o_almost_full=1. Set i_af_thresh=0 -> o_almost_full=1 at count 0.
- At count=3, i_flush together with i_push -> o_count=0, o_empty=1, no overflow. Then at count=3, assert i_rst with i_push -> all outputs at reset values next cycle, o_rdata=0.
